// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared arbiter state encodings and owner constants for the native memory port
package vec_mem_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GNT_CPU,
    ST_GNT_VEC,
    ST_ERR_CPU,
    ST_ERR_VEC
  } state_e;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_VEC = 1'b1;
  localparam int BURST_W = 4;
  localparam logic [BURST_W-1:0] BURST_MAX = '1;
endpackage

// File: rtl/vec_mem_rr_pick.sv
// vec_mem_rr_pick: combinational winner select (cpu_valid, vec_valid, last, fresh, burst_cnt -> any, winner)
module vec_mem_rr_pick
  import vec_mem_pkg::*;
#(
  parameter int VEC_BURST = 4,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic               cpu_valid,
  input  logic               vec_valid,
  input  logic               last,
  input  logic               fresh,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               any,
  output logic               winner
);
  assign any = cpu_valid | vec_valid;
  // fresh covers the first contested pick after reset, where last alone cannot express CPU_FIRST
  always_comb
    winner = !cpu_valid ? OWNER_VEC :
             !vec_valid ? OWNER_CPU :
             fresh ? (CPU_FIRST ? OWNER_CPU : OWNER_VEC) :
             (last == OWNER_VEC) ? (burst_cnt < BURST_W'(VEC_BURST)) : OWNER_VEC;
endmodule

// File: rtl/picorv32_vec_mem_arbiter.sv
// picorv32_vec_mem_arbiter: shares one native memory port between cpu and vec, with bounded vec bursts and out-of-window error completion
// ports: clk/resetn; cpu_mem_* and vec_mem_* requester sides; mem_* downstream side; mem_owner debug; addr_err pulse
module picorv32_vec_mem_arbiter
  import vec_mem_pkg::*;
#(
  parameter int ADDR_LIMIT = 1024,
  parameter int VEC_BURST  = 4,
  parameter bit CPU_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_owner,
  output logic        addr_err
);
  localparam logic [31:0] LIMIT = ADDR_LIMIT;
  state_e state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, fresh_q, fresh_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic any, winner, oor, start;
  logic gnt_cpu, gnt_vec, err_cpu, err_vec, cpu_done, vec_done;
  vec_mem_rr_pick #(.VEC_BURST(VEC_BURST), .CPU_FIRST(CPU_FIRST)) u_pick (
    .cpu_valid(cpu_mem_valid),
    .vec_valid(vec_mem_valid),
    .last     (last_q),
    .fresh    (fresh_q),
    .burst_cnt(burst_q),
    .any      (any),
    .winner   (winner)
  );
  always_comb begin
    gnt_cpu  = state_q == ST_GNT_CPU;
    gnt_vec  = state_q == ST_GNT_VEC;
    err_cpu  = state_q == ST_ERR_CPU;
    err_vec  = state_q == ST_ERR_VEC;
    cpu_done = (gnt_cpu & mem_ready) | err_cpu;
    vec_done = (gnt_vec & mem_ready) | err_vec;
    oor      = (winner ? vec_mem_addr : cpu_mem_addr) >= LIMIT;
    start    = (state_q == ST_IDLE) & any;
    state_d  = state_q == ST_IDLE ?
                 (!any ? ST_IDLE :
                  winner ? (oor ? ST_ERR_VEC : ST_GNT_VEC) : (oor ? ST_ERR_CPU : ST_GNT_CPU)) :
               (cpu_done | vec_done) ? ST_IDLE : state_q;
    last_d   = start ? winner : last_q;
    owner_d  = start ? winner : owner_q;
    fresh_d  = start ? 1'b0 : fresh_q;
    burst_d  = cpu_done ? '0 :
               vec_done ? (burst_q == BURST_MAX ? burst_q : burst_q + 1'b1) : burst_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= ST_IDLE;
      last_q  <= CPU_FIRST ? OWNER_CPU : OWNER_VEC;
      owner_q <= OWNER_CPU;
      fresh_q <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      fresh_q <= fresh_d;
      burst_q <= burst_d;
    end
  // outputs decode straight from state so reset forces them low immediately
  always_comb begin
    mem_valid     = gnt_cpu | gnt_vec;
    mem_addr      = gnt_vec ? vec_mem_addr  : gnt_cpu ? cpu_mem_addr  : '0;
    mem_wdata     = gnt_vec ? vec_mem_wdata : gnt_cpu ? cpu_mem_wdata : '0;
    mem_wstrb     = gnt_vec ? vec_mem_wstrb : gnt_cpu ? cpu_mem_wstrb : '0;
    cpu_mem_ready = cpu_done;
    vec_mem_ready = vec_done;
    cpu_mem_rdata = (gnt_cpu & mem_ready) ? mem_rdata : '0;
    vec_mem_rdata = (gnt_vec & mem_ready) ? mem_rdata : '0;
    addr_err      = err_cpu | err_vec;
    mem_owner     = owner_q;
  end
endmodule

// File: tb/tb_picorv32_vec_mem_arbiter.sv
// tb_picorv32_vec_mem_arbiter: scoreboard and vector-table bench for the cpu/vec memory arbiter
module tb_picorv32_vec_mem_arbiter;
  logic clk = 0, resetn = 0;
  logic cpu_mem_valid = 0, vec_mem_valid = 0;
  logic [31:0] cpu_mem_addr = 0, cpu_mem_wdata = 0, vec_mem_addr = 0, vec_mem_wdata = 0;
  logic [3:0] cpu_mem_wstrb = 0, vec_mem_wstrb = 0;
  logic cpu_mem_ready, vec_mem_ready, mem_valid, mem_owner, addr_err;
  logic [31:0] cpu_mem_rdata, vec_mem_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_ready = 0;
  logic [31:0] mem_rdata = 0;
  picorv32_vec_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr), .vec_mem_wdata(vec_mem_wdata),
    .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_owner(mem_owner), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { bit side; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [31:0] rdata; bit err; } vec_t;
  exp_t cq[$], vq[$];
  bit glog[$];
  logic [7:0] mem [0:1023];
  int total = 0, bad = 0, lat = 1, mcnt = 0, cyc = 0;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // downstream memory: responds lat cycles after the request appears, changes state #1 after posedge
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      mem_ready = 0; mem_rdata = 0; mcnt = 0;
    end else if (mem_ready) begin
      mem_ready = 0; mem_rdata = 0;
    end else if (mem_valid) begin
      if (mcnt >= lat) begin
        automatic int a = int'(mem_addr[9:2]) * 4;
        mem_ready = 1; mcnt = 0;
        mem_rdata = (mem_wstrb != 0) ? 32'h0 : {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) mem[a+b] = mem_wdata[8*b +: 8];
      end else mcnt++;
    end
  end
  // scoreboard: pop expected result on each ready pulse
  always @(negedge clk) if (resetn) begin
    if (cpu_mem_ready && vec_mem_ready) check("both_ready", 1, 0);
    if (addr_err) check("err_no_mem_valid", mem_valid, 0);
    if (cpu_mem_ready) begin
      glog.push_back(0);
      check("cpu_owner", mem_owner, 0);
      if (cq.size() == 0) check("cpu_unexpected_ready", 1, 0);
      else begin
        automatic exp_t e = cq.pop_front();
        check("cpu_rdata", cpu_mem_rdata, e.rdata);
        check("cpu_err", addr_err, e.err);
      end
    end
    if (vec_mem_ready) begin
      glog.push_back(1);
      check("vec_owner", mem_owner, 1);
      if (vq.size() == 0) check("vec_unexpected_ready", 1, 0);
      else begin
        automatic exp_t e = vq.pop_front();
        check("vec_rdata", vec_mem_rdata, e.rdata);
        check("vec_err", addr_err, e.err);
      end
    end
  end
  task automatic do_req(input bit side, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata, input bit err, output int mv);
    bit done = 0;
    exp_t e;
    e.rdata = rdata; e.err = err;
    if (side) begin
      vq.push_back(e);
      vec_mem_addr = addr; vec_mem_wdata = wdata; vec_mem_wstrb = wstrb; vec_mem_valid = 1;
    end else begin
      cq.push_back(e);
      cpu_mem_addr = addr; cpu_mem_wdata = wdata; cpu_mem_wstrb = wstrb; cpu_mem_valid = 1;
    end
    mv = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (mem_valid) mv++;
      done = resetn && (side ? vec_mem_ready : cpu_mem_ready);
    end
    if (!done) check(side ? "vec_timeout" : "cpu_timeout", 0, 1);
    @(posedge clk); #1;
    if (side) vec_mem_valid = 0; else cpu_mem_valid = 0;
  endtask
  vec_t tbl[12];
  bit pat[10];
  int mv0, mv1, c0;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    tbl[0]  = '{0, 32'h10,       32'h01000113, 4'hF, 32'h0,        0};
    tbl[1]  = '{0, 32'h10,       32'h0,        4'h0, 32'h01000113, 0};
    tbl[2]  = '{1, 32'h20,       32'hAABBCCDD, 4'h3, 32'h0,        0};
    tbl[3]  = '{1, 32'h20,       32'h0,        4'h0, 32'h0000CCDD, 0};
    tbl[4]  = '{0, 32'h3FC,      32'h12345678, 4'hF, 32'h0,        0};
    tbl[5]  = '{1, 32'h3FC,      32'h0,        4'h0, 32'h12345678, 0};
    tbl[6]  = '{1, 32'h400,      32'h0,        4'h0, 32'h0,        1};
    tbl[7]  = '{0, 32'h10,       32'h0,        4'h0, 32'h01000113, 0};
    tbl[8]  = '{0, 32'h400,      32'h0000DEAD, 4'hF, 32'h0,        1};
    tbl[9]  = '{1, 32'hFFFFFFFC, 32'h55555555, 4'hF, 32'h0,        1};
    tbl[10] = '{0, 32'h3FF,      32'h0,        4'h0, 32'h12345678, 0};
    tbl[11] = '{1, 32'h3FC,      32'h0,        4'h0, 32'h12345678, 0};
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    // reset with both valids high, then cpu must win the first contested pick
    fork
      do_req(0, 32'h10, 0, 0, 32'h0, 0, mv0);
      do_req(1, 32'h20, 0, 0, 32'h0, 0, mv1);
    join_none
    repeat (3) @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_cpu_ready", cpu_mem_ready, 0);
    check("rst_vec_ready", vec_mem_ready, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_owner", mem_owner, 0);
    @(posedge clk); #1 resetn = 1;
    wait fork;
    check("first_grant_len", glog.size(), 2);
    if (glog.size() == 2) begin
      check("first_grant_cpu", glog[0], 0);
      check("second_grant_vec", glog[1], 1);
    end
    // single transactions from the vector table
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].side, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].rdata, tbl[i].err, mv0);
      check($sformatf("mv_cycles_%0d", i), mv0, tbl[i].err ? 0 : 2);
    end
    // contention: after a cpu access, vec gets 4 then cpu gets 1
    do_req(0, 32'h10, 0, 0, 32'h01000113, 0, mv0);
    glog.delete();
    fork
      for (int i = 0; i < 2; i++) do_req(0, 32'h10, 0, 0, 32'h01000113, 0, mv0);
      for (int j = 0; j < 8; j++) do_req(1, 32'h20, 0, 0, 32'h0000CCDD, 0, mv1);
    join
    check("burst_len", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++) check($sformatf("burst_order_%0d", i), glog[i], pat[i]);
    // unthrottled strided byte stores with cpu idle
    glog.delete();
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      automatic logic [31:0] a = 32'd800 + 32'(i);
      automatic logic [7:0] d = 8'hA0 + 8'(i);
      do_req(1, a, {4{d}}, 4'b0001 << a[1:0], 32'h0, 0, mv1);
    end
    check("stride_cycles", cyc - c0, 48);
    check("stride_grants", glog.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("stride_byte_%0d", i), {24'h0, mem[800+i]}, 32'hA0 + i);
    // asynchronous reset while vec holds the grant with the memory still busy
    lat = 5;
    vec_mem_addr = 32'h20; vec_mem_wstrb = 0; vec_mem_valid = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = mem_valid; end
      check("rst_mid_granted", seen, 1);
    end
    #2 resetn = 0;
    #1;
    check("rst_mid_mem_valid", mem_valid, 0);
    check("rst_mid_owner", mem_owner, 0);
    vec_mem_valid = 0;
    @(negedge clk);
    @(negedge clk);
    lat = 1;
    resetn = 1;
    do_req(0, 32'h10, 0, 0, 32'h01000113, 0, mv0);
    check("post_rst_mv_cycles", mv0, 2);
    check("queues_empty", cq.size() + vq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
